// File: rtl/cmd_dispatch.sv
// Command front end for the unit bus: buffers host command frames, broadcasts them to
// the command units, collects parameter words and response codes, and frames responses.
module cmd_dispatch #(
  parameter int          CMD_BITS    = 8,
  parameter int          NUNITS      = 4,
  parameter int          MAX_ARGS    = 8,
  parameter int          RSP_DEPTH   = 16,
  parameter int          TIMEOUT     = 1024,
  parameter logic [15:0] RSP_UNKNOWN = 16'hffff
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CMD_BITS-1:0]   cmd,
  output logic                  cmd_ready,
  output logic [31:0]           arg_data,
  input  logic [NUNITS-1:0]     arg_advance,
  input  logic [NUNITS-1:0]     cmd_done,
  input  logic [32*NUNITS-1:0]  param_data,
  input  logic [NUNITS-1:0]     param_write,
  input  logic [NUNITS-1:0]     invol_req,
  output logic [NUNITS-1:0]     invol_grant,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int AIW = $clog2(MAX_ARGS);
  localparam int ACW = $clog2(MAX_ARGS + 1);
  localparam int PIW = $clog2(RSP_DEPTH);
  localparam int PCW = $clog2(RSP_DEPTH + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [7:0]     MAX_ARGS_B = 8'(MAX_ARGS);
  localparam logic [PCW-1:0] DEPTH_C    = PCW'(RSP_DEPTH);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOAD_ARGS   = 3'd1;
  localparam logic [2:0] S_ISSUE       = 3'd2;
  localparam logic [2:0] S_RUN         = 3'd3;
  localparam logic [2:0] S_EMIT_HDR    = 3'd4;
  localparam logic [2:0] S_EMIT_PARAMS = 3'd5;

  logic [2:0]          r_state;
  logic [CMD_BITS-1:0] r_cmd;
  logic [7:0]          r_nargs;
  logic [7:0]          r_popCnt;
  logic [31:0]         r_argBuf [MAX_ARGS];
  logic [ACW-1:0]      r_argCnt;
  logic [ACW-1:0]      r_rdPtr;
  logic [31:0]         r_paramBuf [RSP_DEPTH];
  logic [PCW-1:0]      r_paramCnt;
  logic [PIW-1:0]      r_emitPtr;
  logic                r_overflow;
  logic                r_invol;
  logic [15:0]         r_code;
  logic [TW-1:0]       r_timer;
  logic [NUNITS-1:0]   r_grant;

  logic [NUNITS-1:0]   w_grantSel;
  logic [31:0]         w_wrWord;
  logic [15:0]         w_doneCode;
  logic                w_collect;
  logic                w_argStore;
  logic                w_paramStore;
  logic [31:0]         w_outData;
  logic                w_unused;

  // Lowest set index wins for grants, parameter writes and completions alike.
  always_comb begin
    w_grantSel = '0;
    w_wrWord   = '0;
    w_doneCode = '0;
    for (int i = NUNITS - 1; i >= 0; i--) begin
      if (invol_req[i])   w_grantSel = NUNITS'(1) << i;
      if (param_write[i]) w_wrWord   = param_data[i*32 +: 32];
      if (cmd_done[i])    w_doneCode = param_data[i*32 +: 16];
    end
  end

  // The grant cycle itself is not a collection cycle; the unit starts talking after it.
  assign w_collect    = (r_state == S_RUN) && (r_grant == '0);
  assign w_argStore   = (r_state == S_LOAD_ARGS) && in_valid && (r_popCnt < MAX_ARGS_B);
  assign w_paramStore = w_collect && (|param_write) && (r_paramCnt < DEPTH_C);
  assign w_unused     = ^in_data;

  always_ff @(posedge clk) begin
    if (w_argStore)   r_argBuf[r_popCnt[AIW-1:0]]     <= in_data;
    if (w_paramStore) r_paramBuf[r_paramCnt[PIW-1:0]] <= w_wrWord;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_nargs    <= '0;
      r_popCnt   <= '0;
      r_argCnt   <= '0;
      r_rdPtr    <= '0;
      r_paramCnt <= '0;
      r_emitPtr  <= '0;
      r_overflow <= 1'b0;
      r_invol    <= 1'b0;
      r_code     <= '0;
      r_timer    <= '0;
      r_grant    <= '0;
    end else begin
      r_grant <= '0;
      if ((|arg_advance) && (r_rdPtr < r_argCnt)) r_rdPtr <= r_rdPtr + ACW'(1);

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cmd      <= in_data[CMD_BITS-1:0];
            r_nargs    <= in_data[23:16];
            r_popCnt   <= '0;
            r_argCnt   <= '0;
            r_rdPtr    <= '0;
            r_paramCnt <= '0;
            r_overflow <= 1'b0;
            r_invol    <= 1'b0;
            r_timer    <= '0;
            r_state    <= (in_data[23:16] == 8'd0) ? S_ISSUE : S_LOAD_ARGS;
          end else if (|invol_req) begin
            r_grant    <= w_grantSel;
            r_invol    <= 1'b1;
            r_argCnt   <= '0;
            r_rdPtr    <= '0;
            r_paramCnt <= '0;
            r_overflow <= 1'b0;
            r_state    <= S_RUN;
          end
        end

        S_LOAD_ARGS: begin
          if (in_valid) begin
            if (w_argStore) r_argCnt <= r_argCnt + ACW'(1);
            r_popCnt <= r_popCnt + 8'd1;
            if (r_popCnt + 8'd1 == r_nargs) r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_RUN;
        end

        // Completion outranks the timeout; a same-cycle parameter write is still kept.
        S_RUN: begin
          if (w_paramStore) r_paramCnt <= r_paramCnt + PCW'(1);
          else if (w_collect && (|param_write)) r_overflow <= 1'b1;

          if (w_collect && (|cmd_done)) begin
            r_code  <= w_doneCode;
            r_state <= S_EMIT_HDR;
          end else if (!r_invol) begin
            if (r_timer == TIMER_LAST) begin
              r_code     <= RSP_UNKNOWN;
              r_paramCnt <= '0;
              r_overflow <= 1'b0;
              r_state    <= S_EMIT_HDR;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end

        S_EMIT_HDR: begin
          if (out_ready) begin
            r_emitPtr <= '0;
            if (r_paramCnt == '0) begin
              r_invol    <= 1'b0;
              r_overflow <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_state <= S_EMIT_PARAMS;
            end
          end
        end

        S_EMIT_PARAMS: begin
          if (out_ready) begin
            if (PCW'(r_emitPtr) == r_paramCnt - PCW'(1)) begin
              r_invol    <= 1'b0;
              r_overflow <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_emitPtr <= r_emitPtr + PIW'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_outData = '0;
    case (r_state)
      S_EMIT_HDR:    w_outData = {r_invol, r_overflow, 6'b0, 8'(r_paramCnt), r_code};
      S_EMIT_PARAMS: w_outData = r_paramBuf[r_emitPtr];
      default:       w_outData = '0;
    endcase
  end

  assign in_ready    = in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD_ARGS));
  assign cmd         = r_cmd;
  assign cmd_ready   = (r_state == S_ISSUE);
  assign arg_data    = (r_rdPtr < r_argCnt) ? r_argBuf[r_rdPtr[AIW-1:0]] : 32'd0;
  assign invol_grant = r_grant;
  assign out_valid   = (r_state == S_EMIT_HDR) || (r_state == S_EMIT_PARAMS);
  assign out_data    = w_outData;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: table of frames with hand-derived headers, directed corner
// sequences, then random frames checked against a transaction-level response model.
module tb_cmd_dispatch;

  localparam int NUNITS    = 4;
  localparam int RSP_DEPTH = 16;
  localparam int MAX_ARGS  = 8;
  localparam int TIMEOUT   = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   cmd;
  logic         cmd_ready;
  logic [31:0]  arg_data;
  logic [3:0]   arg_advance;
  logic [3:0]   cmd_done;
  logic [127:0] param_data;
  logic [3:0]   param_write;
  logic [3:0]   invol_req;
  logic [3:0]   invol_grant;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  cmdId;
    int          nargs;
    int          nparams;
    logic [15:0] code;
    int          unit;
    bit          sameCycle;
    bit          bp;
    logic [31:0] expHdr;
  } vec_t;

  vec_t vecs[6];

  cmd_dispatch dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .cmd_ready(cmd_ready), .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd_done(cmd_done), .param_data(param_data), .param_write(param_write),
    .invol_req(invol_req), .invol_grant(invol_grant),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, checks so far %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int unit, input bit wr, input bit done, input logic [31:0] word);
    for (int u = 0; u < NUNITS; u++) param_data[u*32 +: 32] = $urandom;
    param_data[unit*32 +: 32] = word;
    param_write = wr ? 4'(1 << unit) : 4'b0;
    cmd_done    = done ? 4'(1 << unit) : 4'b0;
  endtask

  task automatic idleUnits();
    for (int u = 0; u < NUNITS; u++) param_data[u*32 +: 32] = $urandom;
    param_write = '0;
    cmd_done    = '0;
  endtask

  // Response header the host should see for a given outcome.
  function automatic logic [31:0] modelHeader(input bit invol, input int nparams, input logic [15:0] code);
    int kept;
    kept = (nparams > RSP_DEPTH) ? RSP_DEPTH : nparams;
    return {invol, (nparams > RSP_DEPTH), 6'b0, 8'(kept), code};
  endfunction

  task automatic collectResponse(input logic [31:0] expq[$], input bit bp);
    int idx = 0;
    int guard = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    while (idx < expq.size() && guard < 400) begin
      @(negedge clk);
      guard++;
      if (!out_valid) begin
        checkOutput($sformatf("out_valid_word%0d", idx), out_valid, 1);
        break;
      end
      if (stalled) checkOutput("stall_hold", out_data, held);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        checkOutput($sformatf("rsp_word%0d", idx), out_data, expq[idx]);
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = out_data;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    if (idx < expq.size()) checkOutput("frame_complete", idx, expq.size());
    @(negedge clk);
    checkOutput("drained_idle", out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic doCommand(input logic [7:0] cmdId, input int nargs, input int nparams,
                           input logic [15:0] code, input int unit, input bit sameCycle,
                           input bit bp, input logic [31:0] expHdr);
    logic [31:0] args[$];
    logic [31:0] params[$];
    logic [31:0] expq[$];
    logic [31:0] w;
    logic [31:0] expArg;
    int stored;
    in_data  = {8'($urandom), 8'(nargs), 8'($urandom), cmdId};
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("hdr_in_ready", in_ready, 1);
    for (int i = 0; i < nargs; i++) begin
      @(posedge clk); #1;
      w = $urandom;
      args.push_back(w);
      in_data = w;
      @(negedge clk);
      checkOutput("arg_in_ready", in_ready, 1);
      checkOutput("no_early_issue", cmd_ready, 0);
    end
    @(posedge clk); #1;
    in_data = $urandom;
    @(negedge clk);
    stored = (nargs < MAX_ARGS) ? nargs : MAX_ARGS;
    expArg = (stored > 0) ? args[0] : 32'd0;
    checkOutput("issue_strobe", cmd_ready, 1);
    checkOutput("issue_cmd", cmd, cmdId);
    checkOutput("issue_in_ready", in_ready, 0);
    checkOutput("issue_grant", invol_grant, 0);
    checkOutput("issue_arg0", arg_data, expArg);
    in_valid    = 1'b0;
    arg_advance = 4'(1 << unit);
    for (int k = 1; k <= stored + 1; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k == 1) checkOutput("issue_one_cycle", cmd_ready, 0);
      expArg = (k < stored) ? args[k] : 32'd0;
      checkOutput($sformatf("arg%0d", k), arg_data, expArg);
    end
    arg_advance = '0;
    for (int i = 0; i < nparams; i++) begin
      @(posedge clk); #1;
      if (sameCycle && i == nparams - 1) begin
        w = {16'($urandom), code};
        applyStimulus(unit, 1, 1, w);
      end else begin
        w = $urandom;
        applyStimulus(unit, 1, 0, w);
      end
      params.push_back(w);
      if (!(sameCycle && i == nparams - 1) && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        idleUnits();
      end
    end
    if (!(sameCycle && nparams > 0)) begin
      @(posedge clk); #1;
      applyStimulus(unit, 0, 1, {16'($urandom), code});
    end
    @(posedge clk); #1;
    idleUnits();
    @(negedge clk);
    checkOutput("hdr_next_cycle", out_valid, 1);
    expq.push_back(expHdr);
    for (int i = 0; i < params.size() && i < RSP_DEPTH; i++) expq.push_back(params[i]);
    collectResponse(expq, bp);
  endtask

  task automatic doInvol(input logic [3:0] req, input logic [3:0] expGrant, input int unit,
                         input int nparams, input logic [15:0] code, input int delay,
                         input bit bp, input logic [31:0] expHdr);
    logic [31:0] expq[$];
    logic [31:0] w;
    invol_req = req;
    @(negedge clk);
    checkOutput("grant_not_yet", invol_grant, 0);
    @(posedge clk); #1;
    invol_req = '0;
    @(negedge clk);
    checkOutput("grant_onehot", invol_grant, expGrant);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("grant_one_cycle", invol_grant, 0);
    expq.push_back(expHdr);
    for (int i = 0; i < nparams; i++) begin
      @(posedge clk); #1;
      w = $urandom;
      applyStimulus(unit, 1, 0, w);
      if (i < RSP_DEPTH) expq.push_back(w);
    end
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      idleUnits();
    end
    @(negedge clk);
    checkOutput("invol_no_timeout", out_valid, 0);
    @(posedge clk); #1;
    applyStimulus(unit, 0, 1, {16'($urandom), code});
    @(posedge clk); #1;
    idleUnits();
    @(negedge clk);
    checkOutput("invol_hdr_next_cycle", out_valid, 1);
    collectResponse(expq, bp);
  endtask

  initial begin
    logic [31:0] emptyQ[$];
    logic [31:0] hdrQ[$];
    logic [3:0]  req;
    logic [3:0]  grant;
    int          waitCnt;
    int          unit;
    int          np;
    int          na;
    logic [15:0] code;

    vecs[0] = '{8'h00, 0,  3, 16'h0000, 0, 1'b0, 1'b0, 32'h0003_0000};
    vecs[1] = '{8'h21, 2,  0, 16'h0000, 1, 1'b0, 1'b0, 32'h0000_0000};
    vecs[2] = '{8'h05, 1,  2, 16'h1234, 3, 1'b1, 1'b1, 32'h0002_1234};
    vecs[3] = '{8'h7f, 9,  1, 16'h00aa, 2, 1'b0, 1'b1, 32'h0001_00aa};
    vecs[4] = '{8'h10, 0, 19, 16'h0042, 0, 1'b0, 1'b1, 32'h4010_0042};
    vecs[5] = '{8'hc3, 8, 16, 16'hbeef, 1, 1'b1, 1'b0, 32'h0010_beef};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; arg_advance = '0;
    cmd_done = '0; param_data = '0; param_write = '0; invol_req = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_arg_data", arg_data, 0);
    checkOutput("rst_grant", invol_grant, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] table-driven frames");
    for (int v = 0; v < 6; v++)
      doCommand(vecs[v].cmdId, vecs[v].nargs, vecs[v].nparams, vecs[v].code, vecs[v].unit,
                vecs[v].sameCycle, vecs[v].bp, vecs[v].expHdr);

    $display("[TB] unknown command timeout");
    in_data = {8'h00, 8'd1, 8'h00, 8'hee}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'hcafe_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("to_issue", cmd_ready, 1);
    waitCnt = 0;
    while (!out_valid && waitCnt < TIMEOUT + 50) begin
      @(posedge clk); #1;
      waitCnt++;
      if (waitCnt == 3) applyStimulus(2, 1, 0, 32'h1234_5678);
      else idleUnits();
      @(negedge clk);
    end
    checkOutput("to_latency", waitCnt, TIMEOUT + 1);
    hdrQ.delete();
    hdrQ.push_back(32'h0000_ffff);
    collectResponse(hdrQ, 0);

    $display("[TB] command beats involuntary request");
    in_data = {8'h00, 8'd0, 8'h00, 8'h33}; in_valid = 1'b1; invol_req = 4'b1010;
    @(negedge clk);
    checkOutput("prio_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; invol_req = '0;
    @(negedge clk);
    checkOutput("prio_issue", cmd_ready, 1);
    checkOutput("prio_no_grant", invol_grant, 0);
    @(posedge clk); #1;
    applyStimulus(1, 0, 1, 32'h1111_0077);
    @(posedge clk); #1;
    idleUnits();
    hdrQ.delete();
    hdrQ.push_back(32'h0000_0077);
    collectResponse(hdrQ, 0);

    $display("[TB] involuntary messages");
    doInvol(4'b0100, 4'b0100, 2, 1, 16'h0005, 0, 1'b0, 32'h8001_0005);
    doInvol(4'b1010, 4'b0010, 1, 0, 16'h0009, TIMEOUT + 20, 1'b1, 32'h8000_0009);

    $display("[TB] reset during argument load");
    in_data = {8'h00, 8'd5, 8'h00, 8'h44}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 32'haaaa_0001;
    @(posedge clk); #1;
    in_data = 32'haaaa_0002;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_cmd", cmd, 0);
    checkOutput("mid_rst_cmd_ready", cmd_ready, 0);
    checkOutput("mid_rst_arg_data", arg_data, 0);
    checkOutput("mid_rst_grant", invol_grant, 0);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    doCommand(8'h5a, 2, 2, 16'h0102, 3, 1'b0, 1'b0, 32'h0002_0102);

    $display("[TB] randomized frames");
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = 4'($urandom_range(1, 15));
        grant = req & (~req + 4'd1);
        unit = 0;
        for (int u = 0; u < NUNITS; u++) if (grant[u]) unit = u;
        np = $urandom_range(0, 18);
        code = 16'($urandom);
        doInvol(req, grant, unit, np, code, 0, 1'($urandom_range(0, 1)), modelHeader(1, np, code));
      end else begin
        na = $urandom_range(0, 10);
        np = $urandom_range(0, 20);
        code = 16'($urandom);
        doCommand(8'($urandom), na, np, code, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), modelHeader(0, np, code));
      end
    end

    emptyQ.delete();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
